data_mem_responder: RTL and testbench

- Word-addressed data memory slave that answers the processor's mem_read/mem_write requests.
- Access latency is programmable, so the data path can be exercised against non-ideal memory.
- Sits between the processor's data path and backing storage.
- Handshake: the requester holds a level request until a one-cycle mem_ready pulse.
- Flags out-of-range accesses on err.

---
 rtl/data_mem_responder.sv | 139 +++++++++++++
 tb/tb_data_mem_responder.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// Word-addressed data memory slave with programmable access latency.
// Optional DATA_MEM_MISALIGN_TRAP_EN turns unaligned accesses into faults.
module data_mem_responder #(
  parameter int DEPTH_LOG2 = 10,
  parameter int LATENCY    = 2,
  parameter int DATA_W     = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] addr,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        mem_ready,
  output logic        busy,
  output logic        err
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
    $error("data_mem_responder: LATENCY must be 1..15");
  end
  if (DATA_W != 32) begin : g_bad_width
    $error("data_mem_responder: DATA_W must be 32");
  end

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t state;
  logic [3:0] count;
  logic wr_q;
  logic fault_q;
  logic both_q;
  logic [DEPTH_LOG2-1:0] idx_q;
  logic [31:0] wdata_q;
  logic [31:0] mem [DEPTH];

  logic req;
  logic both_in;
  logic range_bad;
  logic align_bad;
  logic fault_in;
  logic [DEPTH_LOG2-1:0] idx_in;
  logic [DEPTH_LOG2-1:0] rd_idx;
  logic rd_bad;
  logic [31:0] rd_word;
  logic commit;

  assign req       = mem_read | mem_write;
  assign both_in   = mem_read & mem_write;
  assign idx_in    = addr[DEPTH_LOG2+1:2];
  assign range_bad = |addr[31:DEPTH_LOG2+2];

`ifdef DATA_MEM_MISALIGN_TRAP_EN
  assign align_bad = |addr[1:0];
`else
  logic unused_lsb;
  assign unused_lsb = ^addr[1:0];
  assign align_bad  = 1'b0;
`endif

  assign fault_in = range_bad | align_bad;

  // With LATENCY=1 the response is formed in IDLE, before the latch exists.
  always_comb begin
    rd_idx  = (state == IDLE) ? idx_in : idx_q;
    rd_bad  = (state == IDLE) ? fault_in : fault_q;
    rd_word = rd_bad ? 32'h0 : mem[rd_idx];
  end

  assign commit = (state == RESP) && wr_q && !fault_q && !rst;

  always_ff @(posedge clk) begin
    if (commit) mem[idx_q] <= wdata_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      count     <= 4'd0;
      wr_q      <= 1'b0;
      fault_q   <= 1'b0;
      both_q    <= 1'b0;
      idx_q     <= '0;
      wdata_q   <= 32'h0;
      read_data <= 32'h0;
      mem_ready <= 1'b0;
      busy      <= 1'b0;
      err       <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          mem_ready <= 1'b0;
          err       <= 1'b0;
          busy      <= req;
          if (req) begin
            wr_q    <= mem_write;
            fault_q <= fault_in;
            both_q  <= both_in;
            idx_q   <= idx_in;
            wdata_q <= write_data;
            count   <= 4'(LATENCY - 1);
            if (LATENCY > 1) begin
              state <= WAIT;
            end else begin
              state     <= RESP;
              mem_ready <= 1'b1;
              err       <= fault_in | both_in;
              if (!mem_write) read_data <= rd_word;
            end
          end
        end
        WAIT: begin
          count <= count - 4'd1;
          if (count == 4'd1) begin
            state     <= RESP;
            mem_ready <= 1'b1;
            err       <= fault_q | both_q;
            if (!wr_q) read_data <= rd_word;
          end
        end
        RESP: begin
          state     <= IDLE;
          mem_ready <= 1'b0;
          busy      <= 1'b0;
          err       <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder at LATENCY=2, DEPTH_LOG2=10.
module tb_data_mem_responder;

  localparam int LAT = 2;

  logic        clk;
  logic        rst;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] addr;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        mem_ready;
  logic        busy;
  logic        err;

  int n_cmp = 0;
  int n_bad = 0;

  data_mem_responder #(
    .DEPTH_LOG2(10),
    .LATENCY(LAT),
    .DATA_W(32)
  ) dut (
    .clk(clk),
    .rst(rst),
    .mem_read(mem_read),
    .mem_write(mem_write),
    .addr(addr),
    .write_data(write_data),
    .read_data(read_data),
    .mem_ready(mem_ready),
    .busy(busy),
    .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one held request; returns edges-to-ready, busy trace, err, data.
  task automatic access(input logic rd, input logic wr,
                        input logic [31:0] a, input logic [31:0] wd,
                        output int lat, output logic [2:0] bseq,
                        output logic e, output logic [31:0] d);
    mem_read   = rd;
    mem_write  = wr;
    addr       = a;
    write_data = wd;
    lat  = 0;
    bseq = 3'b000;
    e    = 1'b0;
    d    = 32'h0;
    while (lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
      if (lat <= 2) bseq[3-lat] = busy;
      if (mem_ready) break;
    end
    e = err;
    d = read_data;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    @(posedge clk);
    #1;
    bseq[0] = busy;
  endtask

  vec_t vt[13];
  int lat;
  logic [2:0] bseq;
  logic e;
  logic [31:0] d;

  initial begin
    vt[0]  = '{1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0};
    vt[1]  = '{1'b1, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0};
    vt[2]  = '{1'b0, 1'b1, 32'h0, 32'h1, 32'h0, 1'b0};
    vt[3]  = '{1'b0, 1'b1, 32'h4, 32'h2, 32'h0, 1'b0};
    vt[4]  = '{1'b1, 1'b0, 32'h0, 32'h0, 32'h1, 1'b0};
    vt[5]  = '{1'b1, 1'b0, 32'h4, 32'h0, 32'h2, 1'b0};
    vt[6]  = '{1'b1, 1'b0, 32'h1000, 32'h0, 32'h0, 1'b1};
    vt[7]  = '{1'b0, 1'b1, 32'h1000, 32'h55, 32'h0, 1'b1};
    vt[8]  = '{1'b1, 1'b0, 32'h0, 32'h0, 32'h1, 1'b0};
    vt[9]  = '{1'b1, 1'b1, 32'h8, 32'h77, 32'h0, 1'b1};
    vt[10] = '{1'b1, 1'b0, 32'h8, 32'h0, 32'h77, 1'b0};
`ifdef DATA_MEM_MISALIGN_TRAP_EN
    vt[11] = '{1'b1, 1'b0, 32'h12, 32'h0, 32'h0, 1'b1};
`else
    vt[11] = '{1'b1, 1'b0, 32'h12, 32'h0, 32'hDEADBEEF, 1'b0};
`endif
    vt[12] = '{1'b1, 1'b0, 32'hFFFFFFFC, 32'h0, 32'h0, 1'b1};

    rst        = 1'b1;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    addr       = 32'h0;
    write_data = 32'h0;
    #12;
    check("reset read_data", read_data, 32'h0);
    check("reset mem_ready", 32'(mem_ready), 32'h0);
    check("reset busy", 32'(busy), 32'h0);
    check("reset err", 32'(err), 32'h0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 13; i++) begin
      access(vt[i].rd, vt[i].wr, vt[i].a, vt[i].wd, lat, bseq, e, d);
      check($sformatf("vec%0d latency", i), 32'(lat), 32'(LAT));
      check($sformatf("vec%0d busy seq", i), 32'(bseq), 32'b110);
      check($sformatf("vec%0d err", i), 32'(e), 32'(vt[i].exp_err));
      if (vt[i].rd && !vt[i].wr)
        check($sformatf("vec%0d read_data", i), d, vt[i].exp_rd);
    end

    // read_data must hold across a following write
    access(1'b1, 1'b0, 32'h10, 32'h0, lat, bseq, e, d);
    check("hold pre-read", d, 32'hDEADBEEF);
    access(1'b0, 1'b1, 32'h3C, 32'h9, lat, bseq, e, d);
    check("hold after write", read_data, 32'hDEADBEEF);
    check("err low in idle", 32'(err), 32'h0);

    // reset during WAIT of a write aborts it
    access(1'b0, 1'b1, 32'h20, 32'h1234, lat, bseq, e, d);
    access(1'b1, 1'b0, 32'h20, 32'h0, lat, bseq, e, d);
    check("pre-reset read", d, 32'h1234);
    mem_write  = 1'b1;
    addr       = 32'h20;
    write_data = 32'hAA;
    @(posedge clk);
    #1;
    check("mid-write busy", 32'(busy), 32'h1);
    #2;
    rst = 1'b1;
    #1;
    check("async rst read_data", read_data, 32'h0);
    check("async rst busy", 32'(busy), 32'h0);
    check("async rst ready", 32'(mem_ready), 32'h0);
    check("async rst err", 32'(err), 32'h0);
    mem_write = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    access(1'b1, 1'b0, 32'h20, 32'h0, lat, bseq, e, d);
    check("post-reset read", d, 32'h1234);
    check("post-reset latency", 32'(lat), 32'(LAT));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
